// File: rtl/rh_gpv_responder_pkg.sv
// rh_gpv_responder_pkg: FSM state type and default sizing constants shared by the GPV echo responder
package rh_gpv_responder_pkg;
   localparam int DEF_WIDTH   = 64;
   localparam int DEF_DEPTH   = 8;
   localparam int DEF_DELAY_W = 8;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_e;
endpackage

// File: rtl/rh_gpv_sync_fifo.sv
// rh_gpv_sync_fifo: pending-event FIFO (storage, wrapping pointers, full/empty/count)
// Ports: clock/reset (sync, active-high), push_i/data_i write side, pop_i read side,
//        head_o current head entry, full_o/empty_o status, count_o occupancy.
module rh_gpv_sync_fifo
   import rh_gpv_responder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             data_i,
   output logic [WIDTH-1:0]             head_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;
   logic             wr_en, rd_en;
   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];
   // a simultaneous pop frees the slot the push lands in, so a full FIFO still accepts it
   assign wr_en   = push_i && (!full_o || pop_i);
   assign rd_en   = pop_i && !empty_o;
   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_q] <= data_i;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + AW'(1);
         if (rd_en) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
      end
   end
endmodule

// File: rtl/rh_gpv_echo_responder.sv
// rh_gpv_echo_responder: captures changes on vector_out and replays them on vector_in after a programmable delay
// Ports: clock/reset (sync, active-high), enable gates change capture, delay extra wait cycles
//        (sampled when an entry is loaded), vector_out stimulus in, vector_in response out,
//        vector_valid one-cycle update pulse, overflow sticky drop flag, depth_cnt FIFO occupancy.
// Build option: define RHGPV_ECHO_INVERT_EN to replay the bitwise inverse of each captured value.
module rh_gpv_echo_responder
   import rh_gpv_responder_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int DELAY_W = DEF_DELAY_W
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [DELAY_W-1:0]           delay,
   input  logic [WIDTH-1:0]             vector_out,
   output logic [WIDTH-1:0]             vector_in,
   output logic                         vector_valid,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   depth_cnt
);
   logic [WIDTH-1:0]   prev_q, head, drive_d;
   logic [DELAY_W-1:0] cnt_q;
   state_e             state_q;
   logic               push, pop, full, empty;
   assign push = enable && (vector_out != prev_q);
   assign pop  = state_q == S_DRIVE;
`ifdef RHGPV_ECHO_INVERT_EN
   assign drive_d = ~head;
`else
   assign drive_d = head;
`endif
   rh_gpv_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (vector_out),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (depth_cnt)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q       <= '0;
         cnt_q        <= '0;
         state_q      <= S_IDLE;
         vector_in    <= '0;
         vector_valid <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         prev_q       <= vector_out;
         vector_valid <= 1'b0;
         if (push && full && !pop) overflow <= 1'b1;
         case (state_q)
            S_IDLE: if (!empty) begin
               cnt_q   <= delay;
               state_q <= (delay == '0) ? S_DRIVE : S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_q - DELAY_W'(1);
               if (cnt_q == DELAY_W'(1)) state_q <= S_DRIVE;
            end
            S_DRIVE: begin
               vector_in    <= drive_d;
               vector_valid <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
